// File: rtl/mem_wb_if.sv
// MEM/WB boundary bundle: EX/MEM-side capture inputs, pipeline control, WB-side outputs.
// Carries no logic; the register stage supplies the one-cycle latency.
// stall/flush travel with the bundle so the stage freezes or drops as a unit.
interface mem_wb_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             stall;
    logic             flush;
    logic             in_valid;
    logic             in_reg_write;
    logic             in_mem_read;
    logic [4:0]       in_rd;
    logic [2:0]       in_funct3;
    logic [1:0]       in_byte_off;
    logic [XLEN-1:0]  in_alu_result;
    logic [XLEN-1:0]  in_mem_rdata;

    logic             wb_valid;
    logic             wb_reg_write;
    logic             wb_mem_read;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_alu_result;
    logic [XLEN-1:0]  wb_load_data;
    logic [XLEN-1:0]  wb_write_data;
    logic [CNT_W-1:0] instret;

    // upstream pipeline / control side
    modport master (
        output stall, flush, in_valid, in_reg_write, in_mem_read, in_rd,
               in_funct3, in_byte_off, in_alu_result, in_mem_rdata,
        input  wb_valid, wb_reg_write, wb_mem_read, wb_rd, wb_alu_result,
               wb_load_data, wb_write_data, instret
    );

    // the MEM/WB register stage itself
    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_mem_read, in_rd,
               in_funct3, in_byte_off, in_alu_result, in_mem_rdata,
        output wb_valid, wb_reg_write, wb_mem_read, wb_rd, wb_alu_result,
               wb_load_data, wb_write_data, instret
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with sub-word load extension and retired-instruction counter.
// Latency: 1 cycle EX/MEM -> WB; only wb_write_data is combinational (mux of registers).
// Backpressure: stall freezes every register and the counter; flush inserts a bubble and wins.
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic      clk,
    input  logic      rst,
    mem_wb_if.slave   bus
);

    logic             vld_q;
    logic             reg_write_q;
    logic             mem_read_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  load_q;
    logic [CNT_W-1:0] instret_q;

    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [XLEN-1:0]  load_ext;
    logic             capture;

    assign capture = !bus.flush && !bus.stall;

    // Pick the addressed byte/half from the aligned word and extend per load type.
    always_comb begin
        sel_byte = bus.in_mem_rdata[7:0];
        case (bus.in_byte_off)
            2'd0:    sel_byte = bus.in_mem_rdata[7:0];
            2'd1:    sel_byte = bus.in_mem_rdata[15:8];
            2'd2:    sel_byte = bus.in_mem_rdata[23:16];
            default: sel_byte = bus.in_mem_rdata[31:24];
        endcase
        sel_half = bus.in_byte_off[1] ? bus.in_mem_rdata[31:16] : bus.in_mem_rdata[15:0];
        load_ext = bus.in_mem_rdata;
        case (bus.in_funct3)
            3'b000:  load_ext = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, sel_byte};
            3'b001:  load_ext = {{(XLEN-16){sel_half[15]}}, sel_half};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, sel_half};
            default: load_ext = bus.in_mem_rdata;
        endcase
    end

    // Stage registers: flush drops to a bubble, stall holds, otherwise capture with
    // write-enable / load flag qualified here so a bubble or x0 can never forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            rd_q        <= 5'd0;
            alu_q       <= '0;
            load_q      <= '0;
        end else if (bus.flush) begin
            vld_q       <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            rd_q        <= 5'd0;
            alu_q       <= '0;
            load_q      <= '0;
        end else if (!bus.stall) begin
            vld_q       <= bus.in_valid;
            reg_write_q <= bus.in_valid && bus.in_reg_write && (bus.in_rd != 5'd0);
            mem_read_q  <= bus.in_valid && bus.in_mem_read;
            rd_q        <= bus.in_rd;
            alu_q       <= bus.in_alu_result;
            load_q      <= load_ext;
        end
    end

    // Count each real instruction captured; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (capture && bus.in_valid) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign bus.wb_valid      = vld_q;
    assign bus.wb_reg_write  = reg_write_q;
    assign bus.wb_mem_read   = mem_read_q;
    assign bus.wb_rd         = rd_q;
    assign bus.wb_alu_result = alu_q;
    assign bus.wb_load_data  = load_q;
    assign bus.wb_write_data = mem_read_q ? load_q : alu_q;
    assign bus.instret       = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: capture, load extension, x0/bubble, stall/flush,
// async reset and counter wrap. A narrow counter keeps the wrap reachable by counting.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
module tb_mem_wb_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_wb_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    mem_wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] alu, input logic [31:0] rdata);
        bus.in_valid      = v;
        bus.in_reg_write  = rw;
        bus.in_mem_read   = mr;
        bus.in_rd         = rd;
        bus.in_funct3     = f3;
        bus.in_byte_off   = off;
        bus.in_alu_result = alu;
        bus.in_mem_rdata  = rdata;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 5'd9, 3'b010, 2'd0, 32'hCAFE, 32'hBEEF);

        // reset held across edges with valid inputs present
        step();
        step();
        check("rst_valid", bus.wb_valid, 0);
        check("rst_reg_write", bus.wb_reg_write, 0);
        check("rst_rd", bus.wb_rd, 0);
        check("rst_write_data", bus.wb_write_data, 0);
        check("rst_instret", bus.instret, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd5, 3'b000, 2'd0, 32'h1234, 32'h0);

        // 1. plain ALU capture
        step();
        check("cap_valid", bus.wb_valid, 1);
        check("cap_reg_write", bus.wb_reg_write, 1);
        check("cap_mem_read", bus.wb_mem_read, 0);
        check("cap_rd", bus.wb_rd, 5);
        check("cap_write_data", bus.wb_write_data, 32'h1234);
        check("cap_instret", bus.instret, 1);

        // 2. loads from 0x80FF7F01 (bytes 01,7F,FF,80 from offset 0)
        drive(1'b1, 1'b1, 1'b1, 5'd7, 3'b000, 2'd3, 32'h5555, 32'h80FF7F01);
        step();
        check("lb_off3", bus.wb_load_data, 32'hFFFFFF80);
        check("lb_wdata", bus.wb_write_data, 32'hFFFFFF80);
        check("lb_mem_read", bus.wb_mem_read, 1);
        drive(1'b1, 1'b1, 1'b1, 5'd7, 3'b100, 2'd1, 32'h5555, 32'h80FF7F01);
        step();
        check("lbu_off1", bus.wb_load_data, 32'h0000007F);
        check("lbu_wdata", bus.wb_write_data, 32'h0000007F);
        drive(1'b1, 1'b1, 1'b1, 5'd7, 3'b001, 2'd2, 32'h5555, 32'h80FF7F01);
        step();
        check("lh_off2", bus.wb_load_data, 32'hFFFF80FF);
        check("lh_wdata", bus.wb_write_data, 32'hFFFF80FF);
        drive(1'b1, 1'b1, 1'b1, 5'd7, 3'b101, 2'd0, 32'h5555, 32'h80FF7F01);
        step();
        check("lhu_off0", bus.wb_load_data, 32'h00007F01);
        check("lhu_wdata", bus.wb_write_data, 32'h00007F01);
        drive(1'b1, 1'b1, 1'b1, 5'd7, 3'b010, 2'd2, 32'h5555, 32'h80FF7F01);
        step();
        check("lw", bus.wb_load_data, 32'h80FF7F01);
        check("lw_wdata", bus.wb_write_data, 32'h80FF7F01);
        check("lw_mem_read", bus.wb_mem_read, 1);
        drive(1'b1, 1'b1, 1'b1, 5'd7, 3'b011, 2'd1, 32'h5555, 32'h80FF7F01);
        step();
        check("f3_other_word", bus.wb_load_data, 32'h80FF7F01);
        check("alu_kept_on_load", bus.wb_alu_result, 32'h5555);
        check("load_instret", bus.instret, 7);

        // 3. x0 destination never writes; bubble does not count
        drive(1'b1, 1'b1, 1'b0, 5'd0, 3'b000, 2'd0, 32'h77, 32'h0);
        step();
        check("x0_reg_write", bus.wb_reg_write, 0);
        check("x0_valid", bus.wb_valid, 1);
        check("x0_instret", bus.instret, 8);
        drive(1'b0, 1'b1, 1'b1, 5'd9, 3'b010, 2'd0, 32'h88, 32'h99);
        step();
        check("bub_valid", bus.wb_valid, 0);
        check("bub_reg_write", bus.wb_reg_write, 0);
        check("bub_mem_read", bus.wb_mem_read, 0);
        check("bub_instret", bus.instret, 8);

        // 4. stall freezes, flush beats stall
        drive(1'b1, 1'b1, 1'b0, 5'd3, 3'b000, 2'd0, 32'hAA, 32'h0);
        step();
        check("pre_stall_instret", bus.instret, 9);
        bus.stall = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd12, 3'b000, 2'd0, 32'h55, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_rd", bus.wb_rd, 3);
            check("stall_wdata", bus.wb_write_data, 32'hAA);
            check("stall_instret", bus.instret, 9);
        end
        bus.flush = 1'b1;
        step();
        check("flush_valid", bus.wb_valid, 0);
        check("flush_rd", bus.wb_rd, 0);
        check("flush_reg_write", bus.wb_reg_write, 0);
        check("flush_alu", bus.wb_alu_result, 0);
        check("flush_instret", bus.instret, 9);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // 5. async reset between edges while a valid load sits in the stage
        drive(1'b1, 1'b1, 1'b1, 5'd4, 3'b010, 2'd0, 32'h11, 32'hDEADBEEF);
        step();
        check("pre_rst_load", bus.wb_write_data, 32'hDEADBEEF);
        check("pre_rst_instret", bus.instret, 10);
        rst = 1'b1;
        #2;
        check("arst_valid", bus.wb_valid, 0);
        check("arst_mem_read", bus.wb_mem_read, 0);
        check("arst_load", bus.wb_load_data, 0);
        check("arst_wdata", bus.wb_write_data, 0);
        check("arst_instret", bus.instret, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_instret", bus.instret, 1);
        check("post_rst_wdata", bus.wb_write_data, 32'hDEADBEEF);

        // 6. counter wrap at 2^CNT_W
        for (int i = 0; i < 14; i++) step();
        check("pre_wrap_instret", bus.instret, 15);
        step();
        check("wrap_instret", bus.instret, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
